// File: rtl/oclib_axim_arbiter.sv
// oclib_axim_arbiter: shares one AXI4 memory port among Ports masters with in-order R/B return
//   clock, resetN   sole clock, asynchronous active-low reset
//   in / inFb       upstream master requests / feedback, one entry per port
//   out / outFb     request / feedback of the shared downstream slave
//   errorSticky     response-ordering error flag
// Optional feature: define OCLIB_AXIM_ARBITER_CHECK_EN to keep AXI ids in the track FIFOs and
// flag responses whose id differs from the oldest outstanding burst, or that arrive with nothing
// outstanding. Without it the ids are not stored and errorSticky is tied low.
package oclib_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [33:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } axi4m_256_a_s;
  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic         last;
  } axi4m_256_w_s;
  typedef struct packed {
    logic [3:0]   id;
    logic [255:0] data;
    logic [1:0]   resp;
    logic         last;
  } axi4m_256_r_s;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } axi4m_256_b_s;
  typedef struct packed {
    logic         awvalid;
    axi4m_256_a_s aw;
    logic         wvalid;
    axi4m_256_w_s w;
    logic         arvalid;
    axi4m_256_a_s ar;
    logic         rready;
    logic         bready;
  } axi4m_256_s;
  typedef struct packed {
    logic         awready;
    logic         wready;
    logic         arready;
    logic         rvalid;
    axi4m_256_r_s r;
    logic         bvalid;
    axi4m_256_b_s b;
  } axi4m_256_fb_s;
endpackage

// oclib_axim_arbiter_track: first-word-fall-through FIFO remembering which port owns each outstanding burst
module oclib_axim_arbiter_track #(
  parameter int Depth = 16,
  parameter int Width = 1
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int AW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int CW = $clog2(Depth) + 1;
  logic [Width-1:0] mem [Depth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  assign empty = count == '0;
  assign full = count == CW'(Depth);
  assign head = mem[rd_ptr];
  always_ff @(posedge clock or negedge resetN)
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == AW'(Depth - 1) ? '0 : wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr == AW'(Depth - 1) ? '0 : rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= din;
endmodule

module oclib_axim_arbiter #(
  parameter int  Ports            = 2,
  parameter type AximType         = oclib_pkg::axi4m_256_s,
  parameter type AximFbType       = oclib_pkg::axi4m_256_fb_s,
  parameter int  ReadOutstanding  = 16,
  parameter int  WriteOutstanding = 16
) (
  input  logic      clock,
  input  logic      resetN,
  input  AximType   in [Ports],
  output AximFbType inFb [Ports],
  output AximType   out,
  input  AximFbType outFb,
  output logic      errorSticky
);
  localparam int PW = Ports > 1 ? $clog2(Ports) : 1;
  localparam int LW = $bits(out.aw.len);
`ifdef OCLIB_AXIM_ARBITER_CHECK_EN
  localparam int IW = $bits(out.ar.id);
  localparam int TW = PW + IW;
`else
  localparam int TW = PW;
`endif
  typedef enum logic {WR_IDLE, WR_DATA} wr_state_e;
  wr_state_e wr_state;
  logic [Ports-1:0] ar_req, aw_req;
  logic [PW-1:0] ar_ptr, aw_ptr, ar_win, aw_win, w_port, rd_port, wr_port;
  logic [LW-1:0] beats_left;
  logic [TW-1:0] rd_din, wr_din, rd_head, wr_head;
  logic ar_any, aw_any, ar_ok, aw_ok, w_ok, ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic r_ready, b_ready, rd_pop, wr_pop, rd_empty, rd_full, wr_empty, wr_full;

  // returns {found, index} of the first requester at or after ptr, wrapping at Ports
  function automatic logic [PW:0] rr_pick(input logic [Ports-1:0] req, input logic [PW-1:0] ptr);
    logic [PW-1:0] idx;
    rr_pick = '0;
    for (int i = Ports - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % Ports);
      if (req[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
    return p == PW'(Ports - 1) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    ar_req = '0;
    aw_req = '0;
    for (int i = 0; i < Ports; i++) begin
      ar_req[i] = in[i].arvalid;
      aw_req[i] = in[i].awvalid;
    end
  end

  assign {ar_any, ar_win} = rr_pick(ar_req, ar_ptr);
  assign {aw_any, aw_win} = rr_pick(aw_req, aw_ptr);
  // resetN gates every forwarded valid so nothing leaks out while reset is held
  assign ar_ok = resetN && ar_any && !rd_full;
  assign aw_ok = resetN && aw_any && !wr_full && wr_state == WR_IDLE;
  assign w_ok = resetN && wr_state == WR_DATA;
  assign ar_hs = ar_ok && outFb.arready;
  assign aw_hs = aw_ok && outFb.awready;
  assign w_hs = w_ok && in[w_port].wvalid && outFb.wready;
  assign rd_port = rd_head[TW-1 -: PW];
  assign wr_port = wr_head[TW-1 -: PW];
  // with nothing outstanding a response has no owner: accept and drop it
  assign r_ready = rd_empty || in[rd_port].rready;
  assign b_ready = wr_empty || in[wr_port].bready;
  assign r_hs = outFb.rvalid && r_ready;
  assign b_hs = outFb.bvalid && b_ready;
  assign rd_pop = r_hs && !rd_empty && outFb.r.last;
  assign wr_pop = b_hs && !wr_empty;

  always_comb begin
    out = '0;
    for (int i = 0; i < Ports; i++) begin
      inFb[i] = '0;
      inFb[i].r = outFb.r;
      inFb[i].b = outFb.b;
    end
    out.ar = in[ar_win].ar;
    out.arvalid = ar_ok;
    inFb[ar_win].arready = ar_hs;
    out.aw = in[aw_win].aw;
    out.awvalid = aw_ok;
    inFb[aw_win].awready = aw_hs;
    out.w = in[w_port].w;
    out.wvalid = w_ok && in[w_port].wvalid;
    inFb[w_port].wready = w_ok && outFb.wready;
    out.rready = r_ready;
    inFb[rd_port].rvalid = !rd_empty && outFb.rvalid;
    out.bready = b_ready;
    inFb[wr_port].bvalid = !wr_empty && outFb.bvalid;
  end

  // burst length comes from aw.len; w.last is forwarded untouched
  always_ff @(posedge clock or negedge resetN)
    if (!resetN) begin
      ar_ptr <= '0;
      aw_ptr <= '0;
      w_port <= '0;
      beats_left <= '0;
      wr_state <= WR_IDLE;
    end else begin
      if (ar_hs) ar_ptr <= next_port(ar_win);
      if (aw_hs) begin
        aw_ptr <= next_port(aw_win);
        w_port <= aw_win;
        beats_left <= in[aw_win].aw.len;
        wr_state <= WR_DATA;
      end
      if (w_hs) begin
        beats_left <= beats_left - LW'(1);
        if (beats_left == '0) wr_state <= WR_IDLE;
      end
    end

`ifdef OCLIB_AXIM_ARBITER_CHECK_EN
  logic r_err, b_err;
  assign rd_din = {ar_win, IW'(in[ar_win].ar.id)};
  assign wr_din = {aw_win, IW'(in[aw_win].aw.id)};
  assign r_err = r_hs && (rd_empty || IW'(outFb.r.id) != rd_head[IW-1:0]);
  assign b_err = b_hs && (wr_empty || IW'(outFb.b.id) != wr_head[IW-1:0]);
  always_ff @(posedge clock or negedge resetN)
    if (!resetN) errorSticky <= 1'b0;
    else if (r_err || b_err) errorSticky <= 1'b1;
`else
  assign rd_din = ar_win;
  assign wr_din = aw_win;
  assign errorSticky = 1'b0;
`endif

  oclib_axim_arbiter_track #(.Depth(ReadOutstanding), .Width(TW)) u_rd_track (
    .clock(clock), .resetN(resetN), .push(ar_hs), .din(rd_din), .pop(rd_pop),
    .head(rd_head), .empty(rd_empty), .full(rd_full)
  );

  oclib_axim_arbiter_track #(.Depth(WriteOutstanding), .Width(TW)) u_wr_track (
    .clock(clock), .resetN(resetN), .push(aw_hs), .din(wr_din), .pop(wr_pop),
    .head(wr_head), .empty(wr_empty), .full(wr_full)
  );
endmodule

// File: tb/tb_oclib_axim_arbiter.sv
// tb_oclib_axim_arbiter: scoreboard bench for the two-port AXI4 arbiter
module tb_oclib_axim_arbiter;
  import oclib_pkg::*;
`ifdef OCLIB_AXIM_ARBITER_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif
  logic clock = 1'b0;
  logic resetN = 1'b1;
  axi4m_256_s in_s [2];
  axi4m_256_fb_s in_fb [2];
  axi4m_256_s out_s;
  axi4m_256_fb_s out_fb;
  logic err;
  int errors = 0;
  int checks = 0;
  int arq[$], awq[$], wq[$], rq[$], bq[$];
  int rid[5] = '{4, 5, 5, 4, 5};
  logic rlast[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  oclib_axim_arbiter #(.Ports(2)) dut (
    .clock(clock), .resetN(resetN), .in(in_s), .inFb(in_fb),
    .out(out_s), .outFb(out_fb), .errorSticky(err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // port currently shown a response valid; -1 for none, 9 for more than one
  function automatic int who_r();
    int g = -1;
    for (int p = 0; p < 2; p++) if (in_fb[p].rvalid) g = (g == -1) ? p : 9;
    return g;
  endfunction

  function automatic int who_b();
    int g = -1;
    for (int p = 0; p < 2; p++) if (in_fb[p].bvalid) g = (g == -1) ? p : 9;
    return g;
  endfunction

  // compares every downstream handshake of this cycle against the scoreboard queues
  task automatic monitor();
    int e;
    if (out_s.arvalid && out_fb.arready) begin
      e = arq.size() != 0 ? arq.pop_front() : -99;
      check("ar_port", 64'(out_s.ar.addr), 64'(e));
      if (e == 0 || e == 1) begin
        check("ar_ready_win", 64'(in_fb[e].arready), 64'(1));
        check("ar_ready_lose", 64'(in_fb[1-e].arready), 64'(0));
      end
    end
    if (out_s.awvalid && out_fb.awready) begin
      e = awq.size() != 0 ? awq.pop_front() : -99;
      check("aw_port", 64'(out_s.aw.addr), 64'(e));
    end
    if (out_s.wvalid && out_fb.wready) begin
      e = wq.size() != 0 ? wq.pop_front() : -99;
      check("w_data", out_s.w.data[63:0], 64'(e));
    end
    if (out_fb.rvalid && out_s.rready) begin
      e = rq.size() != 0 ? rq[0] : -99;
      check("r_port", 64'(who_r()), 64'(e));
      if (out_fb.r.last && rq.size() != 0) void'(rq.pop_front());
    end
    if (out_fb.bvalid && out_s.bready) begin
      e = bq.size() != 0 ? bq.pop_front() : -99;
      check("b_port", 64'(who_b()), 64'(e));
    end
  endtask

  task automatic tick();
    @(negedge clock);
    if (resetN) monitor();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    in_s[0] = '0;
    in_s[1] = '0;
    out_fb = '0;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    clear_inputs();
    repeat (2) tick();
    resetN = 1'b1;
  endtask

  initial begin
    clear_inputs();
    #1;
    resetN = 1'b0;
    in_s[0].arvalid = 1'b1;
    in_s[1].awvalid = 1'b1;
    out_fb.arready = 1'b1;
    out_fb.rvalid = 1'b1;
    out_fb.bvalid = 1'b1;
    #1;
    check("rst_arvalid", 64'(out_s.arvalid), 64'(0));
    check("rst_awvalid", 64'(out_s.awvalid), 64'(0));
    check("rst_wvalid", 64'(out_s.wvalid), 64'(0));
    check("rst_arready", 64'({in_fb[0].arready, in_fb[1].arready}), 64'(0));
    check("rst_rvalid", 64'({in_fb[0].rvalid, in_fb[1].rvalid}), 64'(0));
    check("rst_bvalid", 64'({in_fb[0].bvalid, in_fb[1].bvalid}), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    do_reset();

    // both masters hold arvalid: grants alternate 0,1,0,1, reads return to the granting port
    for (int k = 0; k < 4; k++) begin
      arq.push_back(k % 2);
      rq.push_back(k % 2);
    end
    for (int p = 0; p < 2; p++) begin
      in_s[p].arvalid = 1'b1;
      in_s[p].ar.addr = 34'(p);
      in_s[p].ar.id = 4'(4 + p);
      in_s[p].rready = 1'b1;
    end
    out_fb.arready = 1'b1;
    repeat (4) tick();
    in_s[0].arvalid = 1'b0;
    in_s[1].arvalid = 1'b0;
    out_fb.rvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      out_fb.r.id = 4'(rid[k]);
      out_fb.r.last = rlast[k];
      tick();
    end
    out_fb.rvalid = 1'b0;
    check("r_err_ordered", 64'(err), 64'(0));

    // same-cycle AW: port0 (len 0) first, port1 (len 3) W held off until port0's beat
    awq.push_back(0);
    awq.push_back(1);
    wq.push_back('hA0);
    for (int k = 0; k < 4; k++) wq.push_back('hB0 + k);
    bq.push_back(0);
    bq.push_back(1);
    in_s[0].awvalid = 1'b1;
    in_s[0].aw.addr = 34'(0);
    in_s[0].aw.id = 4'(2);
    in_s[0].aw.len = 8'(0);
    in_s[0].wvalid = 1'b1;
    in_s[0].w.data = 256'('hA0);
    in_s[0].w.last = 1'b1;
    in_s[1].awvalid = 1'b1;
    in_s[1].aw.addr = 34'(1);
    in_s[1].aw.id = 4'(3);
    in_s[1].aw.len = 8'(3);
    in_s[1].wvalid = 1'b1;
    in_s[1].w.data = 256'('hB0);
    out_fb.awready = 1'b1;
    out_fb.wready = 1'b1;
    #1;
    check("w_idle_block", 64'(out_s.wvalid), 64'(0));
    check("aw1_wait", 64'(in_fb[1].awready), 64'(0));
    tick();
    in_s[0].awvalid = 1'b0;
    #1;
    check("aw_in_data", 64'(out_s.awvalid), 64'(0));
    check("w_lock", 64'(in_fb[1].wready), 64'(0));
    check("w_owner_ready", 64'(in_fb[0].wready), 64'(1));
    tick();
    in_s[0].wvalid = 1'b0;
    #1;
    check("w_idle_again", 64'(out_s.wvalid), 64'(0));
    tick();
    in_s[1].awvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_s[1].w.data = 256'('hB0 + k);
      in_s[1].w.last = k == 3;
      tick();
    end
    #1;
    check("w_burst_done", 64'(out_s.wvalid), 64'(0));
    in_s[1].wvalid = 1'b0;
    out_fb.awready = 1'b0;
    out_fb.wready = 1'b0;
    in_s[0].bready = 1'b1;
    in_s[1].bready = 1'b1;
    out_fb.bvalid = 1'b1;
    out_fb.b.id = 4'(2);
    tick();
    out_fb.b.id = 4'(3);
    tick();
    out_fb.bvalid = 1'b0;

    // fill the 16-deep read track, then push and pop in the same cycle
    in_s[0].arvalid = 1'b1;
    in_s[0].ar.addr = 34'(0);
    in_s[0].ar.id = 4'(1);
    out_fb.arready = 1'b1;
    repeat (16) begin
      arq.push_back(0);
      rq.push_back(0);
    end
    repeat (16) tick();
    #1;
    check("full_arvalid", 64'(out_s.arvalid), 64'(0));
    check("full_arready", 64'(in_fb[0].arready), 64'(0));
    tick();
    check("full_hold", 64'(in_fb[0].arready), 64'(0));
    out_fb.rvalid = 1'b1;
    out_fb.r.id = 4'(1);
    out_fb.r.last = 1'b1;
    #1;
    check("full_pop_cycle", 64'(in_fb[0].arready), 64'(0));
    arq.push_back(0);
    rq.push_back(0);
    tick();
    out_fb.rvalid = 1'b0;
    #1;
    check("after_pop_ready", 64'(in_fb[0].arready), 64'(1));
    tick();
    in_s[0].arvalid = 1'b0;
    out_fb.rvalid = 1'b1;
    repeat (16) tick();
    out_fb.rvalid = 1'b0;
    check("drained_err", 64'(err), 64'(0));

    // responses with nothing outstanding are accepted and dropped
    in_s[0].rready = 1'b0;
    in_s[1].rready = 1'b0;
    in_s[0].bready = 1'b0;
    in_s[1].bready = 1'b0;
    out_fb.rvalid = 1'b1;
    out_fb.r.id = 4'(7);
    out_fb.bvalid = 1'b1;
    out_fb.b.id = 4'(7);
    rq.push_back(-1);
    bq.push_back(-1);
    #1;
    check("drop_rready", 64'(out_s.rready), 64'(1));
    check("drop_bready", 64'(out_s.bready), 64'(1));
    tick();
    out_fb.rvalid = 1'b0;
    out_fb.bvalid = 1'b0;
    check("drop_err", 64'(err), 64'(CHK));
    repeat (3) tick();
    check("drop_err_hold", 64'(err), 64'(CHK));

    // id mismatch on the head burst
    do_reset();
    check("err_cleared", 64'(err), 64'(0));
    in_s[1].arvalid = 1'b1;
    in_s[1].ar.addr = 34'(1);
    in_s[1].ar.id = 4'(3);
    out_fb.arready = 1'b1;
    arq.push_back(1);
    rq.push_back(1);
    tick();
    in_s[1].arvalid = 1'b0;
    in_s[1].rready = 1'b1;
    out_fb.rvalid = 1'b1;
    out_fb.r.id = 4'(5);
    out_fb.r.last = 1'b1;
    #1;
    check("err_before", 64'(err), 64'(0));
    tick();
    out_fb.rvalid = 1'b0;
    check("err_mismatch", 64'(err), 64'(CHK));

    // reset in the middle of a 4-beat write burst
    do_reset();
    awq.push_back(0);
    wq.push_back('hC0);
    in_s[0].awvalid = 1'b1;
    in_s[0].aw.addr = 34'(0);
    in_s[0].aw.id = 4'(1);
    in_s[0].aw.len = 8'(3);
    in_s[0].wvalid = 1'b1;
    in_s[0].w.data = 256'('hC0);
    out_fb.awready = 1'b1;
    out_fb.wready = 1'b1;
    tick();
    in_s[0].awvalid = 1'b0;
    tick();
    resetN = 1'b0;
    #1;
    check("rst_mid_wvalid", 64'(out_s.wvalid), 64'(0));
    tick();
    resetN = 1'b1;
    out_fb.awready = 1'b0;
    in_s[0].awvalid = 1'b1;
    in_s[1].awvalid = 1'b1;
    in_s[1].aw.addr = 34'(1);
    #1;
    check("rst_fsm_idle", 64'(out_s.wvalid), 64'(0));
    check("rst_aw_valid", 64'(out_s.awvalid), 64'(1));
    check("rst_awptr", 64'(out_s.aw.addr), 64'(0));
    out_fb.bvalid = 1'b1;
    #1;
    check("rst_wtrack_empty", 64'(out_s.bready), 64'(1));
    check("rst_no_bvalid", 64'(who_b()), 64'(-1));
    out_fb.bvalid = 1'b0;
    clear_inputs();
    tick();
    check("queues_empty", 64'(arq.size() + awq.size() + wq.size() + rq.size() + bq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
